// File: rtl/chess_layout_scanner.sv
// Snapshots the flat 64-square chess layout and streams per-square records to the draw engine.
// Optional LAYOUT_DIFF_EN: emit only squares that changed since the last drawn frame.
module chess_layout_scanner #(
   parameter int CHESS_SQUARES = 64,
   parameter int SQUARE_WIDTH  = 8,
   parameter int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH
) (
   input  logic                    clock,
   input  logic                    resetApp,
   input  logic [MATRIX_WIDTH-1:0] Layout,
   input  logic                    frameStart,
   input  logic                    sqReady,
   output logic                    sqValid,
   output logic [5:0]              sqIdx,
   output logic [2:0]              sqX,
   output logic [2:0]              sqY,
   output logic [3:0]              sqPiece,
   output logic [3:0]              sqSelect,
   output logic                    busy,
   output logic                    frameDone
);

   // Handshake: a record transfers on a cycle where sqValid && sqReady; while
   // sqValid is high without sqReady, every record field holds its value.
   typedef enum logic [2:0] {IDLE, CAPTURE, SCAN, EMIT, DONE} state_t;

   localparam logic [5:0] LAST_IDX = 6'(CHESS_SQUARES - 1);

   state_t                  state, next_state;
   logic [MATRIX_WIDTH-1:0] snapshot;
   logic [5:0]              idx;
   logic [SQUARE_WIDTH-1:0] cur_byte;
   logic                    dirty;
   logic                    last;

   assign cur_byte = snapshot[idx*SQUARE_WIDTH +: SQUARE_WIDTH];
   assign last     = (idx == LAST_IDX);

`ifdef LAYOUT_DIFF_EN
   logic [MATRIX_WIDTH-1:0] shadow;
   logic                    first_frame;

   assign dirty = first_frame | (cur_byte != shadow[idx*SQUARE_WIDTH +: SQUARE_WIDTH]);

   // Shadow tracks what the draw engine has actually accepted.
   always_ff @(posedge clock or posedge resetApp) begin
      if (resetApp) begin
         shadow      <= '0;
         first_frame <= 1'b1;
      end else begin
         if (state == EMIT && sqReady)
            shadow[idx*SQUARE_WIDTH +: SQUARE_WIDTH] <= cur_byte;
         if (state == DONE)
            first_frame <= 1'b0;
      end
   end
`else
   assign dirty = 1'b1;
`endif

   always_ff @(posedge clock or posedge resetApp) begin
      if (resetApp) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (frameStart) next_state = CAPTURE;
         CAPTURE: next_state = SCAN;
         SCAN:    if (dirty)      next_state = EMIT;
                  else if (last)  next_state = DONE;
         EMIT:    if (sqReady)    next_state = last ? DONE : SCAN;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Moore outputs straight from state so an async reset drops them at once.
   always_comb begin
      sqValid   = (state == EMIT);
      busy      = (state != IDLE);
      frameDone = (state == DONE);
   end

   always_ff @(posedge clock or posedge resetApp) begin
      if (resetApp) begin
         snapshot <= '0;
         idx      <= '0;
         sqIdx    <= '0;
         sqPiece  <= '0;
         sqSelect <= '0;
      end else begin
         case (state)
            CAPTURE: begin
               snapshot <= Layout;
               idx      <= '0;
            end
            SCAN: begin
               if (dirty) begin
                  sqIdx    <= idx;
                  sqPiece  <= cur_byte[3:0];
                  sqSelect <= cur_byte[7:4];
               end else if (!last) begin
                  idx <= idx + 6'd1;
               end
            end
            EMIT: if (sqReady && !last) idx <= idx + 6'd1;
            default: ;
         endcase
      end
   end

   assign sqX = sqIdx[2:0];
   assign sqY = sqIdx[5:3];

endmodule

// File: tb/tb_chess_layout_scanner.sv
// Directed bench for chess_layout_scanner: full frames, diff frames, stalls, ignored starts, mid-frame reset.
module tb_chess_layout_scanner;

   localparam int MW = 512;

   logic          clock = 1'b0;
   logic          resetApp;
   logic [MW-1:0] Layout;
   logic          frameStart;
   logic          sqReady;
   logic          sqValid;
   logic [5:0]    sqIdx;
   logic [2:0]    sqX, sqY;
   logic [3:0]    sqPiece, sqSelect;
   logic          busy, frameDone;

   chess_layout_scanner dut (
      .clock(clock), .resetApp(resetApp), .Layout(Layout),
      .frameStart(frameStart), .sqReady(sqReady), .sqValid(sqValid),
      .sqIdx(sqIdx), .sqX(sqX), .sqY(sqY), .sqPiece(sqPiece),
      .sqSelect(sqSelect), .busy(busy), .frameDone(frameDone)
   );

   always #5 clock = ~clock;

   int            n_checks = 0;
   int            n_fails  = 0;
   logic [19:0]   exp_q[$];
   logic [19:0]   rec_seen[64];
   int            n_rec;
   logic [MW-1:0] m_shadow = '0;
   logic          m_first  = 1'b1;

   function automatic logic [19:0] cur_rec();
      return {sqIdx, sqX, sqY, sqSelect, sqPiece};
   endfunction

   // Expected record list derived from the bench's own picture of the board.
   function automatic int build_exp(input logic [MW-1:0] snap);
      int n = 0;
      logic [7:0] b;
      logic [5:0] i6;
      logic       d;
      exp_q.delete();
      for (int i = 0; i < 64; i++) begin
         b  = snap[i*8 +: 8];
         i6 = 6'(i);
`ifdef LAYOUT_DIFF_EN
         d = m_first || (b != m_shadow[i*8 +: 8]);
`else
         d = 1'b1;
`endif
         if (d) begin
            exp_q.push_back({i6, i6[2:0], i6[5:3], b[7:4], b[3:0]});
            n++;
         end
      end
      return n;
   endfunction

   task automatic run_frame(input string name, input int stall, input logic [MW-1:0] stall_layout,
                            input int mid_start);
      logic [MW-1:0] snap;
      logic [19:0]   e;
      int n_dirty, exp_cycle, cyc, stall_left, done_cycle;
      bit done;
      snap       = Layout;
      n_dirty    = build_exp(snap);
      exp_cycle  = 66 + n_dirty + stall;
      stall_left = stall;
      n_rec      = 0;
      done       = 0;
      done_cycle = -1;
      @(posedge clock); #1;
      frameStart = 1'b1;
      sqReady    = 1'b1;
      @(posedge clock); #1;
      frameStart = 1'b0;
      cyc = 1;
      while (!done && cyc < 400) begin
         frameStart = (cyc == mid_start);
         if (sqValid && stall_left > 0) begin
            sqReady = 1'b0;
            if (stall_left == stall) Layout = stall_layout;
            stall_left--;
            n_checks++;
            if (exp_q.size() == 0 || cur_rec() !== exp_q[0]) begin
               n_fails++;
               $display("FAIL %s stall_hold cyc %0d: got %h expected %h", name, cyc, cur_rec(),
                        exp_q.size() ? exp_q[0] : 20'h0);
            end
         end else begin
            sqReady = 1'b1;
         end
         n_checks++;
         if (busy !== 1'b1) begin
            n_fails++;
            $display("FAIL %s busy cyc %0d: got %b expected 1", name, cyc, busy);
         end
         if (sqValid && sqReady) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fails++;
               $display("FAIL %s extra_record: got %h expected none", name, cur_rec());
            end else begin
               e = exp_q.pop_front();
               if (cur_rec() !== e) begin
                  n_fails++;
                  $display("FAIL %s record: got %h expected %h", name, cur_rec(), e);
               end
            end
            if (n_rec < 64) rec_seen[n_rec] = cur_rec();
            n_rec++;
         end
         if (frameDone === 1'b1) begin
            done = 1;
            done_cycle = cyc;
         end else begin
            @(posedge clock); #1;
            cyc++;
         end
      end
      frameStart = 1'b0;
      n_checks++;
      if (done_cycle != exp_cycle) begin
         n_fails++;
         $display("FAIL %s frameDone_cycle: got %0d expected %0d", name, done_cycle, exp_cycle);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL %s missing_records: got %0d left expected 0", name, exp_q.size());
      end
      @(posedge clock); #1;
      n_checks++;
      if (busy !== 1'b0 || frameDone !== 1'b0) begin
         n_fails++;
         $display("FAIL %s idle_after: got busy %b done %b expected 0 0", name, busy, frameDone);
      end
      m_shadow = snap;
      m_first  = 1'b0;
   endtask

   task automatic test_reset();
      resetApp = 1'b1; frameStart = 1'b0; sqReady = 1'b0; Layout = '0;
      repeat (3) @(posedge clock);
      #1;
      n_checks++;
      if ({sqValid, busy, frameDone, sqIdx, sqX, sqY, sqPiece, sqSelect} !== 23'd0) begin
         n_fails++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {sqValid, busy, frameDone, sqIdx, sqX, sqY, sqPiece, sqSelect});
      end
      @(negedge clock); resetApp = 1'b0;
      @(posedge clock); #1;
      n_checks++;
      if ({sqValid, busy, frameDone} !== 3'b000) begin
         n_fails++;
         $display("FAIL reset_release: got %b expected 000", {sqValid, busy, frameDone});
      end
   endtask

   task automatic test_full_frame();
      Layout = '0;
      Layout[26*8 +: 8] = 8'h12;
      run_frame("full_frame", 0, '0, -1);
      n_checks++;
      if (n_rec != 64) begin
         n_fails++;
         $display("FAIL full_frame count: got %0d expected 64", n_rec);
      end
      n_checks++;
      if (rec_seen[26] !== {6'd26, 3'd2, 3'd3, 4'h1, 4'h2}) begin
         n_fails++;
         $display("FAIL full_frame sq26: got %h expected %h", rec_seen[26], {6'd26, 3'd2, 3'd3, 4'h1, 4'h2});
      end
   endtask

   task automatic test_unchanged_frame();
      int exp_n;
      run_frame("unchanged", 0, '0, -1);
`ifdef LAYOUT_DIFF_EN
      exp_n = 0;
`else
      exp_n = 64;
`endif
      n_checks++;
      if (n_rec != exp_n) begin
         n_fails++;
         $display("FAIL unchanged count: got %0d expected %0d", n_rec, exp_n);
      end
   endtask

   task automatic test_partial_change();
      int p25, p26, exp_n;
      Layout[26*8 +: 8] = 8'h02;
      Layout[25*8 +: 8] = 8'h15;
      run_frame("partial", 0, '0, -1);
`ifdef LAYOUT_DIFF_EN
      p25 = 0; p26 = 1; exp_n = 2;
`else
      p25 = 25; p26 = 26; exp_n = 64;
`endif
      n_checks++;
      if (n_rec != exp_n) begin
         n_fails++;
         $display("FAIL partial count: got %0d expected %0d", n_rec, exp_n);
      end
      n_checks++;
      if (rec_seen[p25] !== {6'd25, 3'd1, 3'd3, 4'h1, 4'h5}) begin
         n_fails++;
         $display("FAIL partial sq25: got %h expected %h", rec_seen[p25], {6'd25, 3'd1, 3'd3, 4'h1, 4'h5});
      end
      n_checks++;
      if (rec_seen[p26] !== {6'd26, 3'd2, 3'd3, 4'h0, 4'h2}) begin
         n_fails++;
         $display("FAIL partial sq26: got %h expected %h", rec_seen[p26], {6'd26, 3'd2, 3'd3, 4'h0, 4'h2});
      end
      run_frame("partial_again", 0, '0, -1);
      n_checks++;
      if (n_rec != exp_n - 2 * (exp_n == 2)) begin
         n_fails++;
         $display("FAIL partial_again count: got %0d expected %0d", n_rec, exp_n - 2 * (exp_n == 2));
      end
   endtask

   task automatic test_stall();
      logic [MW-1:0] junk;
      junk = '1;
      Layout[0*8 +: 8]  = 8'hA7;
      Layout[63*8 +: 8] = 8'h3C;
      run_frame("stall", 5, junk, -1);
      n_checks++;
      if (rec_seen[0] !== {6'd0, 3'd0, 3'd0, 4'hA, 4'h7}) begin
         n_fails++;
         $display("FAIL stall sq0: got %h expected %h", rec_seen[0], {6'd0, 3'd0, 3'd0, 4'hA, 4'h7});
      end
   endtask

   task automatic test_ignored_start();
      int extra_done;
      Layout = '0;
      Layout[7*8 +: 8] = 8'h4B;
      run_frame("ignored_start", 0, '0, 20);
      extra_done = 0;
      repeat (8) begin
         @(posedge clock); #1;
         if (frameDone === 1'b1 || busy === 1'b1) extra_done++;
      end
      n_checks++;
      if (extra_done != 0) begin
         n_fails++;
         $display("FAIL ignored_start second_frame: got %0d busy cycles expected 0", extra_done);
      end
   endtask

   task automatic test_reset_mid_frame();
      int  cyc;
      bit  hit;
      hit = 0;
      Layout[10*8 +: 8] = 8'h9E;
      @(posedge clock); #1;
      frameStart = 1'b1; sqReady = 1'b1;
      @(posedge clock); #1;
      frameStart = 1'b0;
      for (cyc = 1; cyc < 400 && !hit; cyc++) begin
         if (sqValid === 1'b1 && sqIdx === 6'd10) begin
            hit = 1;
            sqReady = 1'b0;
         end else begin
            @(posedge clock); #1;
         end
      end
      n_checks++;
      if (!hit) begin
         n_fails++;
         $display("FAIL reset_mid reach_idx10: got timeout expected sqValid at idx 10");
      end
      #2 resetApp = 1'b1;
      #1;
      n_checks++;
      if ({sqValid, busy, frameDone, sqIdx} !== 9'd0) begin
         n_fails++;
         $display("FAIL reset_mid async_clear: got %h expected 0", {sqValid, busy, frameDone, sqIdx});
      end
      @(negedge clock); resetApp = 1'b0;
      m_first = 1'b1;
      run_frame("after_reset", 0, '0, -1);
      n_checks++;
      if (n_rec != 64) begin
         n_fails++;
         $display("FAIL after_reset count: got %0d expected 64", n_rec);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_unchanged_frame();
      test_partial_change();
      test_stall();
      test_ignored_start();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/chess_layout_scanner.md
Name: chess_layout_scanner

Overview:
- Reader/consumer end of the flattened chess layout bus: snapshots the 512-bit Layout word on request and walks all 64 squares.
- Emits per-square records (index, X/Y, piece code, select nibble) over a valid/ready handshake to the board-drawing engine.
- Optionally sends only squares that changed since the last drawn frame.

Parameters:
- CHESS_SQUARES, 64, number of squares; must be 64 (6-bit index, 3-bit X/Y).
- SQUARE_WIDTH, 8, bits per square; [7:4] select nibble, [3:0] piece code.
- MATRIX_WIDTH, CHESS_SQUARES*SQUARE_WIDTH, width of the flat layout bus.

Ports:
- clock  in  1  rising-edge clock.
- resetApp  in  1  reset; asynchronous, active-high.
- Layout  in  MATRIX_WIDTH  flat layout; square i at Layout[i*SQUARE_WIDTH +: SQUARE_WIDTH].
- frameStart  in  1  request one scan; sampled only in IDLE.
- sqReady  in  1  draw engine accepts current record.
- sqValid  out  1  record valid.
- sqIdx  out  6  square index, Y*8+X.
- sqX  out  3  sqIdx[2:0].
- sqY  out  3  sqIdx[5:3].
- sqPiece  out  4  snapshot byte [3:0].
- sqSelect  out  4  snapshot byte [7:4].
- busy  out  1  high in every state except IDLE.
- frameDone  out  1  one-cycle pulse at end of scan.

Behaviour:
- Reset (async): state IDLE; all outputs 0; snapshot, shadow and index cleared; firstFrame=1.
- FSM states: IDLE, CAPTURE, SCAN, EMIT, DONE.
- IDLE: frameStart=1 -> CAPTURE.
- CAPTURE, one cycle: snapshot <= Layout; idx <= 0; -> SCAN.
  - Layout changes after CAPTURE do not affect the current frame.
- SCAN, one cycle per square: dirty = firstFrame | (snapshot[idx] != shadow[idx]).
  - Dirty: load outputs from snapshot[idx]; sqValid <= 1; -> EMIT.
  - Clean with idx==63: -> DONE.
  - Clean otherwise: idx++ and stay in SCAN.
- EMIT: sqIdx/sqX/sqY/sqPiece/sqSelect hold stable while sqValid=1 and sqReady=0.
  - On sqValid&sqReady: shadow[idx] <= snapshot[idx]; sqValid <= 0.
  - Then idx==63 -> DONE, else idx++ -> SCAN.
  - sqValid never drops without acceptance.
- DONE, one cycle: frameDone=1; firstFrame <= 0; -> IDLE.
- frameStart while busy=1 is ignored; not queued.
- Timing:
  - frameStart sampled in cycle 0 -> CAPTURE in cycle 1 -> SCAN idx0 in cycle 2 -> sqValid high at earliest in cycle 3.
  - All squares dirty, sqReady tied high: 2 cycles per square; frameDone in cycle 130.
  - No squares dirty: frameDone in cycle 66.
- Reset mid-frame: immediate return to IDLE; sqValid drops asynchronously; next frame is a full redraw (firstFrame=1).

Optional Feature:
- Macro: LAYOUT_DIFF_EN.
- Defined: shadow register and dirty compare as above; only changed squares are emitted after the first frame.
- Undefined: no shadow storage; every square is treated as dirty; all 64 records are emitted every frame, in index order.

Test Plan:
- Reset, then a Layout with byte 0x12 at square 26 and 0x00 elsewhere, frameStart, sqReady=1 -> 64 records idx 0..63; idx26 gives X=2 Y=3 select=1 piece=2; frameDone in cycle 130.
- Second frame with Layout unchanged (LAYOUT_DIFF_EN) -> zero records; frameDone in cycle 66; busy high for cycles 1..66.
- Byte at square 26 changed to 0x02 and square 25 to 0x15, frameStart -> exactly two records, idx25 (sel1,pc5) then idx26 (sel0,pc2); shadow updated so a third frame emits none.
- sqReady held low for 5 cycles on the first record -> sqValid and all fields stable for those cycles; Layout changed during the stall has no effect on emitted data.
- frameStart pulsed mid-scan -> ignored, single frameDone. resetApp asserted during EMIT at idx 10 -> sqValid=0 at once, state IDLE; next frame emits all 64 records.
